// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned WORD_STRIDE    = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned CNT_W          = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic takes_byte(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
  endfunction

  function automatic logic holds_cpu(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) ||
           (s == ST_WRITE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian stream bytes into a word; flags when the next byte completes it.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              take,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              last_byte
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;

  // First byte shifts down to bits 7:0 once the word is complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      word      <= '0;
      last_byte <= 1'b0;
    end else if (take) begin
      idx       <= idx + IDX_W'(1);
      word      <= {data, word[WORD_W-1:8]};
      last_byte <= (idx == IDX_W'(BYTES_PER_WORD - 2));
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a length-prefixed byte stream while holding the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         rx_ready,
  output logic         imem_we,
  output logic [N-1:0] imem_addr,
  output logic [N-1:0] imem_wdata,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    remaining;
  logic [CNT_W-1:0]    len_c;
  logic                take_c;
  logic                last_byte;
  logic [WORD_W-1:0]   word;

  assign take_c = rx_valid && rx_ready;
  // During LEN1 the low count byte is parked in the remaining counter.
  assign len_c  = {rx_data, remaining[7:0]};

  imem_loader_word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .take      (take_c && (state == ST_DATA)),
    .data      (rx_data),
    .word      (word),
    .last_byte (last_byte)
  );

  assign imem_wdata = N'(word);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (load_en) state_nx = ST_LEN0;
      ST_LEN0:  if (take_c) state_nx = ST_LEN1;
      ST_LEN1: begin
        if (take_c) begin
          if (len_c == '0)              state_nx = ST_DONE;
          else if (32'(len_c) > DEPTH)  state_nx = ST_ERR;
          else                          state_nx = ST_DATA;
        end
      end
      ST_DATA:  if (take_c && last_byte) state_nx = ST_WRITE;
      ST_WRITE: state_nx = (remaining == CNT_W'(1)) ? ST_DONE : ST_DATA;
      ST_DONE,
      ST_ERR:   if (!load_en) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered as decodes of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      imem_addr <= N'(BASE_ADDR);
      rx_ready  <= 1'b0;
      imem_we   <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state    <= state_nx;
      rx_ready <= takes_byte(state_nx);
      imem_we  <= (state_nx == ST_WRITE);
      cpu_hold <= holds_cpu(state_nx);
      done     <= (state_nx == ST_DONE);
      error    <= (state_nx == ST_ERR);
      case (state)
        ST_LEN0: if (take_c) remaining <= CNT_W'(rx_data);
        ST_LEN1: begin
          if (take_c) begin
            remaining <= len_c;
            imem_addr <= N'(BASE_ADDR);
          end
        end
        ST_WRITE: begin
          remaining <= remaining - CNT_W'(1);
          imem_addr <= imem_addr + N'(WORD_STRIDE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed streams, writes checked by a monitor.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.N(32), .DEPTH(256), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h want none", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[63:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // Called just after a negedge; returns on the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    else @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t s, input int gap, output int lapses);
    lapses = 0;
    foreach (s[i]) begin
      send_byte(s[i]);
      if (i != s.size() - 1) begin
        repeat (gap) begin
          if (cpu_hold !== 1'b1) lapses++;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_status(input string name);
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check(name, 32'(done), 32'd1);
  endtask

  initial begin
    bq_t s;
    int  lap;
    reset    = 1'b0;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two-word load, back-to-back bytes
    push_exp(32'h0, 32'h0000_0013);
    push_exp(32'h4, 32'h0010_0093);
    load_en = 1'b1;
    s = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_seq(s, 0, lap);
    wait_status("t1_done_timeout");
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_writes_left", 32'(exp_q.size()), 32'd0);
    load_en = 1'b0;
    @(negedge clk);
    check("t1_idle_done", 32'(done), 32'd0);

    // Same stream with 3-cycle valid gaps
    push_exp(32'h0, 32'h0000_0013);
    push_exp(32'h4, 32'h0010_0093);
    load_en = 1'b1;
    send_seq(s, 3, lap);
    check("t2_hold_lapses", 32'(lap), 32'd0);
    wait_status("t2_done_timeout");
    check("t2_done", 32'(done), 32'd1);
    check("t2_writes_left", 32'(exp_q.size()), 32'd0);
    load_en = 1'b0;
    @(negedge clk);

    // Zero-length load goes straight to DONE
    load_en = 1'b1;
    s = {8'h00, 8'h00};
    send_seq(s, 0, lap);
    check("t3_done_now", 32'(done), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd0);
    load_en = 1'b0;
    @(negedge clk);
    check("t3_idle_done", 32'(done), 32'd0);

    // Oversize count (DEPTH+1) ends in ERR
    load_en = 1'b1;
    s = {8'h01, 8'h01};
    send_seq(s, 0, lap);
    check("t4_error", 32'(error), 32'd1);
    check("t4_rx_ready", 32'(rx_ready), 32'd0);
    check("t4_hold", 32'(cpu_hold), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_error_held", 32'(error), 32'd1);
    load_en = 1'b0;
    @(negedge clk);
    check("t4_idle_error", 32'(error), 32'd0);
    check("t4_idle_hold", 32'(cpu_hold), 32'd0);

    // Asynchronous reset partway through word 0, then a fresh load
    load_en = 1'b1;
    s = {8'h02, 8'h00, 8'hAA, 8'hBB};
    send_seq(s, 0, lap);
    #2 reset = 1'b0;
    #1;
    check("t5_rx_ready", 32'(rx_ready), 32'd0);
    check("t5_we", 32'(imem_we), 32'd0);
    check("t5_addr", imem_addr, 32'h0);
    check("t5_wdata", imem_wdata, 32'h0);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    push_exp(32'h0, 32'h1234_5678);
    s = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_seq(s, 0, lap);
    wait_status("t5_done_timeout");
    check("t5_reload_done", 32'(done), 32'd1);
    check("t5_writes_left", 32'(exp_q.size()), 32'd0);

    // load_en held high through DONE must not restart
    repeat (10) @(negedge clk);
    check("t6_done_held", 32'(done), 32'd1);
    check("t6_no_restart", 32'(rx_ready), 32'd0);
    load_en = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'(done), 32'd0);
    load_en = 1'b1;
    @(negedge clk);
    check("t6_len0_ready", 32'(rx_ready), 32'd1);
    check("t6_len0_hold", 32'(cpu_hold), 32'd1);
    push_exp(32'h0, 32'hDEAD_BEEF);
    s = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(s, 0, lap);
    wait_status("t6_done_timeout");
    check("t6_done", 32'(done), 32'd1);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    check("final_writes_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
